// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception code map, ExcCode values
// and Status/Cause bit positions.
package cp0_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;
  localparam logic [31:0] STATUS_RST = 32'h1000_0000;

  // CP0 register numbers
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  // Encoded exception codes from the priority encoder
  localparam logic [31:0] CODE_NONE     = 32'd0;
  localparam logic [31:0] CODE_INT_LO   = 32'd1;
  localparam logic [31:0] CODE_INT_HI   = 32'd8;
  localparam logic [31:0] CODE_SYSCALL  = 32'd9;
  localparam logic [31:0] CODE_RESINSTR = 32'd10;
  localparam logic [31:0] CODE_OVERFLOW = 32'd11;
  localparam logic [31:0] CODE_TRAP     = 32'd12;
  localparam logic [31:0] CODE_ERET     = 32'd13;

  // ExcCode field values
  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;
  localparam logic [4:0] EXCCODE_TRAP = 5'd13;

  // Status / Cause bit positions
  localparam int STATUS_IE   = 0;
  localparam int STATUS_EXL  = 1;
  localparam int CAUSE_BD    = 31;
  localparam int CAUSE_IP_HI = 15;
  localparam int CAUSE_IP_HW = 10;  // lowest hardware-driven IP bit (IP2)
  localparam int CAUSE_IP_SW = 9;   // highest software-writable IP bit (IP1)
  localparam int CAUSE_IP_LO = 8;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_EXC,
    EV_ERET
  } exc_event_e;

  // Classify an encoded exception code; out-of-range codes mean "nothing".
  function automatic exc_event_e decode_event(input logic [31:0] code);
    if (code >= CODE_INT_LO && code <= CODE_TRAP) return EV_EXC;
    if (code == CODE_ERET) return EV_ERET;
    return EV_NONE;
  endfunction

  // ExcCode for an exception-entry code (interrupts all map to 0).
  function automatic logic [4:0] exc_code_of(input logic [31:0] code);
    case (code)
      CODE_SYSCALL:  return EXCCODE_SYS;
      CODE_RESINSTR: return EXCCODE_RI;
      CODE_OVERFLOW: return EXCCODE_OV;
      CODE_TRAP:     return EXCCODE_TRAP;
      default:       return EXCCODE_INT;
    endcase
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running counter, mtc0-writable compare, and a
// latched interrupt that sets on a nonzero match and clears on Compare write.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        timer_int_reg;
  logic        count_wr;
  logic        compare_wr;
  logic        match;

  assign count_wr   = we_i && (waddr_i == REG_COUNT);
  assign compare_wr = we_i && (waddr_i == REG_COMPARE);
  assign match      = (compare_reg != 32'd0) && (count_reg == compare_reg);

  // Counter, compare register and sticky interrupt; a Compare write beats a match.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= 32'd0;
      compare_reg   <= 32'd0;
      timer_int_reg <= 1'b0;
    end else begin
      count_reg <= count_wr ? wdata_i : count_reg + 32'd1;
      if (compare_wr) begin
        compare_reg   <= wdata_i;
        timer_int_reg <= 1'b0;
      end else if (match) begin
        timer_int_reg <= 1'b1;
      end
    end
  end

  assign count_o     = count_reg;
  assign compare_o   = compare_reg;
  assign timer_int_o = timer_int_reg;

endmodule

// File: rtl/cp0_exception_ctrl.sv
// CP0 register bank and exception sequencer: Status/Cause/EPC update on
// exception entry and ERET, registered flush/redirect, mfc0 read with bypass.
module cp0_exception_ctrl
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] except_code_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [5:0]  hw_int_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  logic [31:0] status_reg, status_next;
  logic [31:0] cause_reg, cause_next;
  logic [31:0] epc_reg, epc_next;
  logic        flush_reg, flush_next;
  logic [31:0] new_pc_reg, new_pc_next;
  logic [5:0]  ip_hw;
  logic [31:0] cause_wr_value;
  exc_event_e  event_kind;

  cp0_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .timer_int_o (timer_int_o)
  );

  // Hardware IP lines; the timer interrupt shares IP7 with hw_int_i[5].
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_ip_hw
      assign ip_hw[gi] = hw_int_i[gi];
    end
  endgenerate
  assign ip_hw[5] = hw_int_i[5] | timer_int_o;

  // Cause as an mtc0 write would leave it: only the software IP bits change.
  assign cause_wr_value = {cause_reg[31:CAUSE_IP_SW+1],
                           wdata_i[CAUSE_IP_SW:CAUSE_IP_LO],
                           cause_reg[CAUSE_IP_LO-1:0]};

  assign event_kind = decode_event(except_code_i);

  // Next-state: mtc0 first, then exception/ERET overrides the fields it owns.
  always_comb begin
    status_next = status_reg;
    cause_next  = cause_reg;
    epc_next    = epc_reg;
    flush_next  = 1'b0;
    new_pc_next = 32'd0;

    if (we_i && waddr_i == REG_STATUS) status_next = wdata_i;
    if (we_i && waddr_i == REG_EPC)    epc_next    = wdata_i;
    if (we_i && waddr_i == REG_CAUSE)  cause_next  = cause_wr_value;
    cause_next[CAUSE_IP_HI:CAUSE_IP_HW] = ip_hw;

    case (event_kind)
      EV_EXC: begin
        // Nested exception (EXL already set) keeps the original EPC/BD.
        if (!status_reg[STATUS_EXL]) begin
          epc_next             = in_delayslot_i ? pc_i - 32'd4 : pc_i;
          cause_next[CAUSE_BD] = in_delayslot_i;
        end
        cause_next[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code_of(except_code_i);
        status_next[STATUS_EXL] = 1'b1;
        flush_next  = 1'b1;
        new_pc_next = EXC_VECTOR;
      end
      EV_ERET: begin
        status_next[STATUS_EXL] = 1'b0;
        flush_next  = 1'b1;
        new_pc_next = epc_reg;
      end
      default: ;
    endcase
  end

  // CP0 register and flush/redirect state.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_reg <= STATUS_RST;
      cause_reg  <= 32'd0;
      epc_reg    <= 32'd0;
      flush_reg  <= 1'b0;
      new_pc_reg <= 32'd0;
    end else begin
      status_reg <= status_next;
      cause_reg  <= cause_next;
      epc_reg    <= epc_next;
      flush_reg  <= flush_next;
      new_pc_reg <= new_pc_next;
    end
  end

  // mfc0 read; a same-cycle write to the same register is forwarded.
  always_comb begin
    rdata_o = 32'd0;
    if (we_i && waddr_i == raddr_i) begin
      case (raddr_i)
        REG_COUNT, REG_COMPARE, REG_STATUS, REG_EPC: rdata_o = wdata_i;
        REG_CAUSE: rdata_o = cause_wr_value;
        default:   rdata_o = 32'd0;
      endcase
    end else begin
      case (raddr_i)
        REG_COUNT:   rdata_o = count_o;
        REG_COMPARE: rdata_o = compare_o;
        REG_STATUS:  rdata_o = status_reg;
        REG_CAUSE:   rdata_o = cause_reg;
        REG_EPC:     rdata_o = epc_reg;
        default:     rdata_o = 32'd0;
      endcase
    end
  end

  assign status_o = status_reg;
  assign cause_o  = cause_reg;
  assign epc_o    = epc_reg;
  assign flush_o  = flush_reg;
  assign new_pc_o = new_pc_reg;

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Self-checking bench for cp0_exception_ctrl: directed scenarios plus
// randomized traffic compared against a behavioural CP0 model.
module tb_cp0_exception_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] except_code_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [5:0]  hw_int_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [31:0] status_o, cause_o, epc_o, count_o, compare_o, new_pc_o;
  logic        timer_int_o, flush_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_status, m_cause, m_epc, m_count, m_compare, m_newpc;
  logic        m_tint, m_flush;

  cp0_exception_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .except_code_i  (except_code_i),
    .pc_i           (pc_i),
    .in_delayslot_i (in_delayslot_i),
    .hw_int_i       (hw_int_i),
    .we_i           (we_i),
    .waddr_i        (waddr_i),
    .wdata_i        (wdata_i),
    .raddr_i        (raddr_i),
    .rdata_o        (rdata_o),
    .status_o       (status_o),
    .cause_o        (cause_o),
    .epc_o          (epc_o),
    .count_o        (count_o),
    .compare_o      (compare_o),
    .timer_int_o    (timer_int_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: apply the CP0 rules for one clock edge using the current inputs.
  task automatic model_step();
    logic [31:0] code, s, c, e, cnt, cmp, npc;
    logic [4:0]  ec;
    logic        t, is_exc, is_eret;
    if (rst) begin
      m_status = 32'h1000_0000; m_cause = 0; m_epc = 0; m_count = 0;
      m_compare = 0; m_tint = 0; m_flush = 0; m_newpc = 0;
      return;
    end
    code    = (except_code_i > 13) ? 32'd0 : except_code_i;
    is_exc  = (code >= 1 && code <= 12);
    is_eret = (code == 13);
    case (code)
      9:  ec = 5'd8;
      10: ec = 5'd10;
      11: ec = 5'd12;
      12: ec = 5'd13;
      default: ec = 5'd0;
    endcase
    s = m_status; c = m_cause; e = m_epc;
    if (we_i && waddr_i == 12) s = wdata_i;
    if (we_i && waddr_i == 14) e = wdata_i;
    if (we_i && waddr_i == 13) c[9:8] = wdata_i[9:8];
    c[15:10] = {hw_int_i[5] | m_tint, hw_int_i[4:0]};
    npc = 0;
    if (is_exc) begin
      if (m_status[1] == 1'b0) begin
        e = in_delayslot_i ? pc_i - 4 : pc_i;
        c[31] = in_delayslot_i;
      end
      c[6:2] = ec;
      s[1] = 1'b1;
      npc = 32'h20;
    end
    if (is_eret) begin
      s[1] = 1'b0;
      npc = m_epc;
    end
    cnt = (we_i && waddr_i == 9) ? wdata_i : m_count + 1;
    cmp = (we_i && waddr_i == 11) ? wdata_i : m_compare;
    if (we_i && waddr_i == 11) t = 1'b0;
    else t = m_tint | (m_compare != 0 && m_count == m_compare);
    m_status = s; m_cause = c; m_epc = e; m_count = cnt; m_compare = cmp;
    m_tint = t; m_flush = is_exc | is_eret; m_newpc = npc;
  endtask

  // Model: mfc0 read result for the current inputs.
  function automatic logic [31:0] model_rdata();
    logic [31:0] c;
    if (we_i && waddr_i == raddr_i) begin
      c = m_cause;
      c[9:8] = wdata_i[9:8];
      case (raddr_i)
        9, 11, 12, 14: return wdata_i;
        13: return c;
        default: return 32'd0;
      endcase
    end
    case (raddr_i)
      9:  return m_count;
      11: return m_compare;
      12: return m_status;
      13: return m_cause;
      14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    except_code_i = 0; pc_i = 0; in_delayslot_i = 0; hw_int_i = 0;
    we_i = 0; waddr_i = 0; wdata_i = 0; raddr_i = 0;
  endtask

  // One clock edge for DUT and model; returns 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    raddr_i = 12; #2;
    checks++; if (rdata_o !== 32'h1000_0000) begin errors++; $display("FAIL reset_status rdata=%h exp=%h", rdata_o, 32'h1000_0000); end
    raddr_i = 13; #1;
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_cause rdata=%h exp=0", rdata_o); end
    raddr_i = 14; #1;
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_epc rdata=%h exp=0", rdata_o); end
    checks++; if (flush_o !== 1'b0 || new_pc_o !== 32'h0 || timer_int_o !== 1'b0) begin errors++; $display("FAIL reset_flush flush=%b new_pc=%h tint=%b exp 0/0/0", flush_o, new_pc_o, timer_int_o); end
    $display("reset: status/cause/epc read back, flush=%b", flush_o);
  endtask

  task automatic test_syscall();
    except_code_i = 9; pc_i = 32'h100; in_delayslot_i = 0;
    tick();
    except_code_i = 0;
    checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h20) begin errors++; $display("FAIL syscall_flush flush=%b new_pc=%h exp 1/00000020", flush_o, new_pc_o); end
    checks++; if (epc_o !== 32'h100) begin errors++; $display("FAIL syscall_epc epc=%h exp=00000100", epc_o); end
    checks++; if (cause_o[6:2] !== 5'd8 || cause_o[31] !== 1'b0) begin errors++; $display("FAIL syscall_cause cause=%h exp exccode 8 bd 0", cause_o); end
    checks++; if (status_o[1] !== 1'b1) begin errors++; $display("FAIL syscall_exl status=%h exp exl=1", status_o); end
    tick();
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL syscall_pulse flush=%b exp=0", flush_o); end
    $display("syscall: epc=%h cause=%h status=%h", epc_o, cause_o, status_o);
  endtask

  task automatic test_eret();
    except_code_i = 13;
    tick();
    except_code_i = 0;
    checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h100) begin errors++; $display("FAIL eret_flush flush=%b new_pc=%h exp 1/00000100", flush_o, new_pc_o); end
    checks++; if (status_o[1] !== 1'b0) begin errors++; $display("FAIL eret_exl status=%h exp exl=0", status_o); end
    tick();
    $display("eret: new_pc=%h status=%h", m_newpc, status_o);
  endtask

  task automatic test_delayslot();
    except_code_i = 11; pc_i = 32'h204; in_delayslot_i = 1;
    tick();
    except_code_i = 0; in_delayslot_i = 0;
    checks++; if (epc_o !== 32'h200) begin errors++; $display("FAIL ds_epc epc=%h exp=00000200", epc_o); end
    checks++; if (cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd12) begin errors++; $display("FAIL ds_cause cause=%h exp bd=1 exccode=12", cause_o); end
    $display("delayslot: epc=%h cause=%h", epc_o, cause_o);
  endtask

  // EXL is still set from the previous entry: a second held code re-flushes
  // but must leave EPC/BD alone.
  task automatic test_back_to_back();
    except_code_i = 12; pc_i = 32'h400; in_delayslot_i = 0;
    tick();
    checks++; if (flush_o !== 1'b1 || epc_o !== 32'h200 || cause_o[31] !== 1'b1) begin errors++; $display("FAIL nested_keep flush=%b epc=%h cause=%h exp flush 1 epc 00000200 bd 1", flush_o, epc_o, cause_o); end
    checks++; if (cause_o[6:2] !== 5'd13) begin errors++; $display("FAIL nested_exccode cause=%h exp exccode 13", cause_o); end
    except_code_i = 20;
    tick();
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL big_code flush=%b exp=0", flush_o); end
    except_code_i = 3;
    tick();
    checks++; if (flush_o !== 1'b1 || cause_o[6:2] !== 5'd0) begin errors++; $display("FAIL int_code flush=%b cause=%h exp flush 1 exccode 0", flush_o, cause_o); end
    rst = 1'b1; except_code_i = 0;
    tick();
    rst = 1'b0;
    checks++; if (flush_o !== 1'b0 || status_o !== 32'h1000_0000) begin errors++; $display("FAIL reset_mid_flush flush=%b status=%h exp 0/10000000", flush_o, status_o); end
    $display("back_to_back: nested entry keeps epc, reset clears flush");
  endtask

  task automatic test_timer();
    int seen;
    we_i = 1; waddr_i = 9; wdata_i = 10;
    tick();
    waddr_i = 11; wdata_i = 20;
    tick();
    we_i = 0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      if (timer_int_o === 1'b1) seen = 1;
      else tick();
    end
    checks++;
    if (seen == 0) begin errors++; $display("FAIL timer_set tint=%b exp=1 within 40 cycles", timer_int_o); end
    else if (count_o !== 32'd21) begin errors++; $display("FAIL timer_set_count count=%0d exp=21", count_o); end
    tick();
    checks++; if (cause_o[15] !== 1'b1) begin errors++; $display("FAIL timer_ip7 cause=%h exp bit15=1", cause_o); end
    we_i = 1; waddr_i = 11; wdata_i = 32'h5000;
    tick();
    we_i = 0;
    checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL timer_clear tint=%b exp=0", timer_int_o); end
    $display("timer: compare=%h count=%0d tint=%b", compare_o, count_o, timer_int_o);
  endtask

  task automatic test_cause_write();
    do_reset();
    we_i = 1; waddr_i = 13; wdata_i = 32'hFFFF_FFFF; raddr_i = 13;
    #2;
    checks++; if (rdata_o !== 32'h0000_0300) begin errors++; $display("FAIL cause_bypass rdata=%h exp=00000300", rdata_o); end
    tick();
    we_i = 0;
    checks++; if (cause_o !== 32'h0000_0300) begin errors++; $display("FAIL cause_masked cause=%h exp=00000300", cause_o); end
    $display("cause_write: cause=%h", cause_o);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 5))
      0: return 5'd9;
      1: return 5'd11;
      2: return 5'd12;
      3: return 5'd13;
      4: return 5'd14;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] exp_rd;
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      except_code_i  = ($urandom_range(0, 9) < 6) ? 32'd0 : 32'($urandom_range(0, 16));
      pc_i           = $urandom;
      in_delayslot_i = 1'($urandom_range(0, 1));
      hw_int_i       = 6'($urandom);
      we_i           = ($urandom_range(0, 2) == 0);
      waddr_i        = pick_reg();
      wdata_i        = ($urandom_range(0, 3) == 0) ? m_count + 32'd2 : $urandom;
      raddr_i        = ($urandom_range(0, 3) == 0) ? waddr_i : pick_reg();
      #2;
      exp_rd = model_rdata();
      checks++;
      if (rdata_o !== exp_rd) begin errors++; bad++; $display("FAIL rand_rdata[%0d] raddr=%0d rdata=%h exp=%h", i, raddr_i, rdata_o, exp_rd); end
      tick();
      checks++;
      if (status_o !== m_status || cause_o !== m_cause || epc_o !== m_epc) begin
        errors++; bad++;
        $display("FAIL rand_regs[%0d] status=%h/%h cause=%h/%h epc=%h/%h (got/exp)", i, status_o, m_status, cause_o, m_cause, epc_o, m_epc);
      end
      checks++;
      if (count_o !== m_count || compare_o !== m_compare || timer_int_o !== m_tint) begin
        errors++; bad++;
        $display("FAIL rand_timer[%0d] count=%h/%h compare=%h/%h tint=%b/%b (got/exp)", i, count_o, m_count, compare_o, m_compare, timer_int_o, m_tint);
      end
      checks++;
      if (flush_o !== m_flush || new_pc_o !== m_newpc) begin
        errors++; bad++;
        $display("FAIL rand_flush[%0d] flush=%b/%b new_pc=%h/%h (got/exp)", i, flush_o, m_flush, new_pc_o, m_newpc);
      end
    end
    idle_inputs();
    $display("random: 300 cycles, %0d mismatching comparisons", bad);
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_syscall();
    test_eret();
    test_delayslot();
    test_back_to_back();
    test_timer();
    test_cause_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_exception_ctrl.md
# cp0_exception_ctrl

Coprocessor-0 register bank and exception sequencer for the pipelined MIPS core, sitting directly downstream of the interrupt/exception priority encoder. It consumes the encoded exception code, updates Status/Cause/EPC, and issues a one-cycle pipeline flush with the redirect PC. It also runs the Count/Compare timer and drives the live Status/Cause values back to the encoder.

## Interface
- `EXC_VECTOR`, 32'h0000_0020: handler entry PC for every interrupt and exception.
- `STATUS_RST`, 32'h1000_0000: Status reset value (CU0=1, IE=0, EXL=0).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `except_code_i` in 32: encoded exception code, 0 = none.
- `pc_i` in 32: PC of the instruction in the exception stage.
- `in_delayslot_i` in 1: that instruction is in a branch delay slot.
- `hw_int_i` in 6: external interrupt lines, level-sensitive.
- `we_i` in 1: mtc0 write strobe.
- `waddr_i` in 5: CP0 register number for the mtc0 write.
- `wdata_i` in 32: mtc0 write data.
- `raddr_i` in 5: CP0 register number for mfc0.
- `rdata_o` out 32: mfc0 read data, combinational.
- `status_o`, `cause_o`, `epc_o` out 32 each: registered CP0 registers, fed to the encoder.
- `count_o`, `compare_o` out 32 each: timer registers.
- `timer_int_o` out 1: latched timer interrupt.
- `flush_o` out 1: one-cycle pipeline flush pulse.
- `new_pc_o` out 32: redirect target, valid only while `flush_o`=1.

## Operation
- CP0 register numbers: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Reads of any other number return 0.
- Code map and ExcCode (Cause[6:2]):
  - 1–8 interrupt IP0–IP7, ExcCode 0.
  - 9 syscall, ExcCode 8.
  - 10 reserved instruction, ExcCode 10.
  - 11 overflow, ExcCode 12.
  - 12 trap, ExcCode 13.
  - 13 ERET.
  - Codes above 13 are treated as 0.
- Exception entry (code 1–12):
  - If `in_delayslot_i`=1: EPC←`pc_i`−4 and Cause.BD(31)←1.
  - Otherwise: EPC←`pc_i` and BD←0.
  - ExcCode is set per the code map.
  - Status.EXL(1)←1.
  - `flush_o`=1 and `new_pc_o`=`EXC_VECTOR` on the following cycle.
  - If EXL was already 1 at entry, EPC and BD are not updated; ExcCode is still updated and the flush still occurs.
- ERET (code 13):
  - Status.EXL←0.
  - Next cycle: `flush_o`=1 and `new_pc_o` = the EPC value at the time ERET was presented.
- mtc0 write fields:
  - Status and EPC: all 32 bits.
  - Cause: only IP[1:0] (bits 9:8).
  - Count: all bits.
  - Compare: all bits; the write also clears `timer_int_o`.
- Cause.IP[7:2] is resampled every cycle as {`hw_int_i`[5] | `timer_int_o`, `hw_int_i`[4:0]} and is never written by mtc0.
- Timer:
  - Count increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0.
  - When Compare≠0 and Count==Compare, `timer_int_o` sets on the next edge and holds until a Compare write or reset.
- Read bypass: if `we_i`=1 and `waddr_i`==`raddr_i`, `rdata_o` returns the value that the write will produce (field-masked for Cause), not the stale register value.

## Timing
- Reset values:
  - Status=`STATUS_RST`.
  - Cause, EPC, Count, Compare = 0.
  - `timer_int_o`=0, `flush_o`=0, `new_pc_o`=0.
- Register update latency is one edge; `flush_o` is registered and therefore lags `except_code_i` by exactly one cycle.
- `flush_o` is high for exactly one cycle per nonzero code. A code held for N cycles gives N entries, so upstream must squash the code once the flush fires.
- Simultaneous exception and mtc0 to Status/Cause/EPC: the exception update wins for the fields it touches; other fields still take the mtc0 value.
- Simultaneous mtc0 to Count and increment: the written value is loaded, with no increment that cycle.
- Simultaneous Compare write and Count==Compare match: the clear wins.
- Reset asserted mid-flush: `flush_o` drops on the next edge.

## Structure
- Shared package `cp0_pkg` holds:
  - register numbers;
  - ExcCode values;
  - code-map constants;
  - Status/Cause bit positions (EXL=1, IE=0, BD=31, IP=15:8, ExcCode=6:2).
- One natural sub-module, `cp0_timer`, holds Count, Compare, and the match/latch logic.

## Test plan
- Reset, then read regs 12/13/14 → 32'h1000_0000 / 0 / 0; `flush_o`=0.
- Code 9 with `pc_i`=32'h100, no delay slot → next cycle `flush_o`=1, `new_pc_o`=32'h20, EPC=32'h100, ExcCode=8, EXL=1.
- Code 11 with `pc_i`=32'h204 in a delay slot → EPC=32'h200, BD=1, ExcCode=12.
- After entry, present code 13 → next cycle `flush_o`=1, `new_pc_o`=EPC, EXL=0.
- Write Compare=20 at Count=10 → `timer_int_o`=1 after Count reaches 20, Cause[15]=1; write Compare again → `timer_int_o`=0.
- mtc0 Cause with 32'hFFFF_FFFF → only bits 9:8 change; same-cycle read of reg 13 shows the masked value.
